// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: FSM states,
// instruction opcode/funct fields and datapath mux/ALU select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_R   = 4'd2,
    S_EX_I   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_MEM = 4'd7,
    S_WB_ALU = 4'd8,
    S_BR     = 4'd9,
    S_JMP    = 4'd10,
    S_HALT   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  localparam logic [1:0] PC_SRC_ALU = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  // Decode-stage dispatch; S_IF marks an unsupported opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:        return S_EX_R;
      OP_ADDI, OP_ORI: return S_EX_I;
      OP_LW, OP_SW:    return S_ADDR;
      OP_BEQ, OP_BNE:  return S_BR;
      OP_J:            return S_JMP;
      default:         return S_IF;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct field to ALU operation decoder with a legality flag.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       legal
);

  // Map supported funct codes; anything else is flagged illegal.
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle CPU control unit: sequences fetch/decode/execute/memory/
// write-back and issues all datapath control strobes. A memory wait
// watchdog halts the machine with a sticky bus_err.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_we,
  output logic       ir_we,
  output logic [1:0] pc_src,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;
  logic             waiting;
  logic             wait_hit;
  logic [3:0]       dec_op;
  logic             fn_legal;

  mc_alu_dec u_alu_dec (
    .funct  (funct),
    .alu_op (dec_op),
    .legal  (fn_legal)
  );

  assign state = cur;

  // A memory request is outstanding in the three strobe states until ready.
  assign waiting  = ((cur == S_IF) || (cur == S_MEM_RD) || (cur == S_MEM_WR)) && !mem_ready;
  assign wait_hit = waiting && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clock) begin
    if (rst) cur <= S_IF;
    else     cur <= nxt;
  end

  // Consecutive-wait counter; any ready cycle or strobe-free state clears it.
  always_ff @(posedge clock) begin
    if (rst)          wait_cnt <= '0;
    else if (waiting) wait_cnt <= wait_cnt + CNT_W'(1);
    else              wait_cnt <= '0;
  end

  // Sticky bus error, cleared only by reset.
  always_ff @(posedge clock) begin
    if (rst)           bus_err_q <= 1'b0;
    else if (wait_hit) bus_err_q <= 1'b1;
  end

  // Next-state and control outputs, all low unless the state asserts them.
  always_comb begin
    nxt        = cur;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    pc_src     = PC_SRC_ALU;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_RT;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    bus_err    = bus_err_q;

    case (cur)
      S_IF: begin
        mem_rd    = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_ID;
        end
      end
      S_ID: begin
        // Branch target is computed speculatively into ALUOut here.
        alu_src_b = SRC_B_IMM_SH;
        nxt       = decode_next(opcode);
        if (nxt == S_IF) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        if (fn_legal) begin
          alu_op = dec_op;
          nxt    = S_WB_ALU;
        end else begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          nxt        = S_IF;
        end
      end
      S_EX_I: begin
        // A operand is rs for immediate arithmetic.
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
        nxt       = S_WB_ALU;
      end
      S_ADDR: begin
        // Effective address = rs + sign-extended offset.
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
        nxt       = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ready) nxt = S_WB_MEM;
      end
      S_MEM_WR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          nxt        = S_IF;
        end
      end
      S_WB_MEM: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt        = S_IF;
      end
      S_WB_ALU: begin
        // IR is still stable, so opcode tells R-type (rd) from I-type (rt).
        reg_we     = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        instr_done = 1'b1;
        nxt        = S_IF;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = PC_SRC_BR;
        pc_we      = (opcode == OP_BNE) ? !alu_zero : alu_zero;
        instr_done = 1'b1;
        nxt        = S_IF;
      end
      S_JMP: begin
        pc_we      = 1'b1;
        pc_src     = PC_SRC_JMP;
        instr_done = 1'b1;
        nxt        = S_IF;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IF;
    endcase

    if (wait_hit) nxt = S_HALT;

    // Reset silences every strobe immediately, aborting any instruction.
    if (rst) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      pc_src     = PC_SRC_ALU;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      iord       = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_RT;
      alu_op     = ALU_ADD;
      instr_done = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

endmodule
